// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - MEM stage opcodes, FSM state encodings and byte-lane constants
package mem_pkg;

  localparam logic [3:0] MEM_OP_NOP = 4'd0;
  localparam logic [3:0] MEM_OP_LB  = 4'd1;
  localparam logic [3:0] MEM_OP_LBU = 4'd2;
  localparam logic [3:0] MEM_OP_LH  = 4'd3;
  localparam logic [3:0] MEM_OP_LHU = 4'd4;
  localparam logic [3:0] MEM_OP_LW  = 4'd5;
  localparam logic [3:0] MEM_OP_SB  = 4'd6;
  localparam logic [3:0] MEM_OP_SH  = 4'd7;
  localparam logic [3:0] MEM_OP_SW  = 4'd8;
  localparam logic [3:0] MEM_OP_LL  = 4'd9;
  localparam logic [3:0] MEM_OP_SC  = 4'd10;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Big-endian lanes: byte 0 of a word lives in bits [31:24]
  localparam logic [3:0] BSEL_B0 = 4'b1000;
  localparam logic [3:0] BSEL_B1 = 4'b0100;
  localparam logic [3:0] BSEL_B2 = 4'b0010;
  localparam logic [3:0] BSEL_B3 = 4'b0001;
  localparam logic [3:0] BSEL_H0 = 4'b1100;
  localparam logic [3:0] BSEL_H1 = 4'b0011;
  localparam logic [3:0] BSEL_W  = 4'b1111;

  function automatic logic op_is_load(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW, MEM_OP_LL};
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, MEM_OP_SC};
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - valid/ack data bus between the MEM stage and memory
interface mem_access_stage_if;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic        bus_ack;
  logic [31:0] bus_read_data;

  modport master (
    output bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
    input  bus_ack, bus_read_data
  );

  modport slave (
    input  bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
    output bus_ack, bus_read_data
  );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/halfword of a load and extends it
module load_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] read_data,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Pick the big-endian lane, then sign- or zero-extend by opcode
  always_comb begin
    case (addr_lo)
      2'd0:    byte_val = read_data[31:24];
      2'd1:    byte_val = read_data[23:16];
      2'd2:    byte_val = read_data[15:8];
      default: byte_val = read_data[7:0];
    endcase
    half_val = addr_lo[1] ? read_data[15:0] : read_data[31:16];
    case (op)
      MEM_OP_LB:  data = {{24{byte_val[7]}}, byte_val};
      MEM_OP_LBU: data = {24'h0, byte_val};
      MEM_OP_LH:  data = {{16{half_val[15]}}, half_val};
      MEM_OP_LHU: data = {16'h0, half_val};
      default:    data = read_data;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: loads/stores over valid/ack bus, MEM/WB register; LL/SC under LLSC_EN
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                ex_operation,
  input  logic [DATA_WIDTH-1:0]     ex_address,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic                      ex_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_address,
  input  logic [DATA_WIDTH-1:0]     ex_write_data,
  input  logic                      llbit_clear,
  mem_access_stage_if.master        bus,
  output logic                      stall_request,
  output logic                      mem_is_load,
  output logic [REG_ADDR_WIDTH-1:0] mem_write_address,
  output logic                      wb_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] wb_write_address,
  output logic [DATA_WIDTH-1:0]     wb_write_data
);

  logic [0:0]                state;
  logic [3:0]                op_q;
  logic [1:0]                addr_lo_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;
  logic                      ack;
  logic                      ex_load, ex_store, ex_sc_fail, ex_llsc_nop;
  logic [3:0]                lane_sel;
  logic [DATA_WIDTH-1:0]     lane_data;
  logic [DATA_WIDTH-1:0]     aligned;

  // An ack with no request outstanding is meaningless and must not advance the FSM
  assign ack = bus.bus_request & bus.bus_ack;

`ifdef LLSC_EN
  logic llbit;

  assign ex_sc_fail  = (ex_operation == MEM_OP_SC) && !llbit;
  assign ex_llsc_nop = 1'b0;
  assign ex_load     = op_is_load(ex_operation);
  assign ex_store    = op_is_store(ex_operation) && !ex_sc_fail;

  // Link bit: set by a completed LL, consumed by a completed SC; an explicit clear wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      llbit <= 1'b0;
    end else if (llbit_clear) begin
      llbit <= 1'b0;
    end else if (state == ST_ACCESS && ack) begin
      if (op_q == MEM_OP_LL) llbit <= 1'b1;
      else if (op_q == MEM_OP_SC) llbit <= 1'b0;
    end
  end
`else
  wire unused_llbit_clear = llbit_clear;

  assign ex_sc_fail  = 1'b0;
  assign ex_llsc_nop = (ex_operation == MEM_OP_LL) || (ex_operation == MEM_OP_SC);
  assign ex_load     = op_is_load(ex_operation) && !ex_llsc_nop;
  assign ex_store    = op_is_store(ex_operation) && !ex_llsc_nop;
`endif

  // Lane enables and replicated store data for the op waiting in EX
  always_comb begin
    lane_sel  = BSEL_W;
    lane_data = ex_store_data;
    case (ex_operation)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        case (ex_address[1:0])
          2'd0:    lane_sel = BSEL_B0;
          2'd1:    lane_sel = BSEL_B1;
          2'd2:    lane_sel = BSEL_B2;
          default: lane_sel = BSEL_B3;
        endcase
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: lane_sel = ex_address[1] ? BSEL_H1 : BSEL_H0;
      default: ;
    endcase
    if (ex_operation == MEM_OP_SB) lane_data = {4{ex_store_data[7:0]}};
    if (ex_operation == MEM_OP_SH) lane_data = {2{ex_store_data[15:0]}};
  end

  load_align u_load_align (
    .op        (op_q),
    .addr_lo   (addr_lo_q),
    .read_data (bus.bus_read_data),
    .data      (aligned)
  );

  // Hold EX while an access is starting or still waiting for its ack
  always_comb begin
    if (state == ST_IDLE) begin
      stall_request     = ex_load | ex_store;
      mem_is_load       = ex_load;
      mem_write_address = ex_write_address;
    end else begin
      stall_request     = !ack;
      mem_is_load       = op_is_load(op_q);
      mem_write_address = rt_q;
    end
  end

  // Access FSM, bus request registers and MEM/WB register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= ST_IDLE;
      op_q                <= MEM_OP_NOP;
      addr_lo_q           <= 2'b00;
      rt_q                <= '0;
      bus.bus_request     <= 1'b0;
      bus.bus_write       <= 1'b0;
      bus.bus_address     <= '0;
      bus.bus_byte_select <= 4'b0000;
      bus.bus_write_data  <= '0;
      wb_write_enable     <= 1'b0;
      wb_write_address    <= '0;
      wb_write_data       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_load || ex_store) begin
            state               <= ST_ACCESS;
            op_q                <= ex_operation;
            addr_lo_q           <= ex_address[1:0];
            rt_q                <= ex_write_address;
            bus.bus_request     <= 1'b1;
            bus.bus_write       <= ex_store;
            bus.bus_address     <= {ex_address[DATA_WIDTH-1:2], 2'b00};
            bus.bus_byte_select <= lane_sel;
            bus.bus_write_data  <= lane_data;
            wb_write_enable     <= 1'b0;
          end else if (ex_sc_fail) begin
            wb_write_enable  <= 1'b1;
            wb_write_address <= ex_write_address;
            wb_write_data    <= '0;
          end else begin
            wb_write_enable  <= ex_write_enable & !ex_llsc_nop;
            wb_write_address <= ex_write_address;
            wb_write_data    <= ex_write_data;
          end
        end
        default: begin
          if (ack) begin
            state            <= ST_IDLE;
            bus.bus_request  <= 1'b0;
            wb_write_enable  <= op_is_load(op_q) || (op_q == MEM_OP_SC);
            wb_write_address <= rt_q;
            wb_write_data    <= (op_q == MEM_OP_SC) ? 32'd1 : aligned;
          end else begin
            wb_write_enable <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench with a cycle-level reference model for mem_access_stage
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  ex_operation;
  logic [31:0] ex_address, ex_store_data, ex_write_data;
  logic        ex_write_enable;
  logic [4:0]  ex_write_address;
  logic        llbit_clear;
  logic        stall_request, mem_is_load, wb_write_enable;
  logic [4:0]  mem_write_address, wb_write_address;
  logic [31:0] wb_write_data;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_load, exp_req, exp_bw, exp_wb_we;
  logic [4:0]  exp_mwa, exp_wb_addr;
  logic [31:0] exp_baddr, exp_bwd, exp_wb_data;
  logic [3:0]  exp_bsel;
  logic        m_llbit;
  int          stall_cnt;
  logic [3:0]  seen_bsel;
  logic [31:0] seen_wdata, seen_addr;
  logic        seen_bw;

  mem_access_stage_if bif ();

  mem_access_stage dut (
    .clock             (clock),
    .reset             (reset),
    .ex_operation      (ex_operation),
    .ex_address        (ex_address),
    .ex_store_data     (ex_store_data),
    .ex_write_enable   (ex_write_enable),
    .ex_write_address  (ex_write_address),
    .ex_write_data     (ex_write_data),
    .llbit_clear       (llbit_clear),
    .bus               (bif),
    .stall_request     (stall_request),
    .mem_is_load       (mem_is_load),
    .mem_write_address (mem_write_address),
    .wb_write_enable   (wb_write_enable),
    .wb_write_address  (wb_write_address),
    .wb_write_data     (wb_write_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

`ifdef LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  function automatic logic [3:0] m_bsel(input logic [3:0] op, input logic [31:0] a);
    if (op == 1 || op == 2 || op == 6) return 4'b1000 >> a[1:0];
    if (op == 3 || op == 4 || op == 7) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] s);
    if (op == 6) return {s[7:0], s[7:0], s[7:0], s[7:0]};
    if (op == 7) return {s[15:0], s[15:0]};
    return s;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = rd >> (8 * (3 - a[1:0]));
    h = rd >> (16 * (1 - a[1]));
    case (op)
      4'd1:    return {{24{b[7]}}, b[7:0]};
      4'd2:    return {24'h0, b[7:0]};
      4'd3:    return {{16{h[15]}}, h[15:0]};
      4'd4:    return {16'h0, h[15:0]};
      default: return rd;
    endcase
  endfunction

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("stall_request", stall_request, exp_stall);
      check("bus_request", bif.bus_request, exp_req);
      if (exp_req) begin
        check("bus_write", bif.bus_write, exp_bw);
        check("bus_address", bif.bus_address, exp_baddr);
        check("bus_byte_select", bif.bus_byte_select, exp_bsel);
        if (exp_bw) check("bus_write_data", bif.bus_write_data, exp_bwd);
      end
      check("mem_is_load", mem_is_load, exp_load);
      if (exp_load) check("mem_write_address", mem_write_address, exp_mwa);
      check("wb_write_enable", wb_write_enable, exp_wb_we);
      if (exp_wb_we) begin
        check("wb_write_address", wb_write_address, exp_wb_addr);
        check("wb_write_data", wb_write_data, exp_wb_data);
      end
      if (stall_request) stall_cnt++;
      if (bif.bus_request) begin
        seen_bsel  = bif.bus_byte_select;
        seen_wdata = bif.bus_write_data;
        seen_addr  = bif.bus_address;
        seen_bw    = bif.bus_write;
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] wa, input logic we, input logic [31:0] wd,
                       input int delay, input logic [31:0] rdata);
    logic is_ld, is_st, sc_fail;
    is_ld   = (op >= 1 && op <= 5) || (LLSC && op == 9);
    is_st   = (op >= 6 && op <= 8) || (LLSC && op == 10 && m_llbit);
    sc_fail = LLSC && op == 10 && !m_llbit;
    ex_operation = op; ex_address = addr; ex_store_data = sdata;
    ex_write_address = wa; ex_write_enable = we; ex_write_data = wd;
    stall_cnt = 0;
    exp_stall = is_ld || is_st;
    exp_load  = is_ld;
    exp_mwa   = wa;
    exp_req   = 1'b0;
    step();
    if (!(is_ld || is_st)) begin
      if (sc_fail) begin
        exp_wb_we = 1'b1; exp_wb_addr = wa; exp_wb_data = 32'd0;
      end else if (op == 9 || op == 10) begin
        exp_wb_we = 1'b0;
      end else begin
        exp_wb_we = we; exp_wb_addr = wa; exp_wb_data = wd;
      end
    end else begin
      exp_req   = 1'b1;
      exp_bw    = is_st;
      exp_baddr = {addr[31:2], 2'b00};
      exp_bsel  = m_bsel(op, addr);
      exp_bwd   = m_wdata(op, sdata);
      exp_wb_we = 1'b0;
      for (int w = 0; w <= delay; w++) begin
        bif.bus_ack       = (w == delay);
        bif.bus_read_data = (w == delay) ? rdata : 32'hDEADBEEF;
        exp_stall         = (w != delay);
        step();
      end
      bif.bus_ack = 1'b0;
      exp_req     = 1'b0;
      if (is_ld) begin
        exp_wb_we = 1'b1; exp_wb_addr = wa; exp_wb_data = m_load(op, addr, rdata);
      end else if (op == 10) begin
        exp_wb_we = 1'b1; exp_wb_addr = wa; exp_wb_data = 32'd1;
      end
      if (op == 9) m_llbit = 1'b1;
      if (op == 10) m_llbit = 1'b0;
    end
  endtask

  task automatic idle(input logic clr);
    ex_operation = 4'd0; ex_write_enable = 1'b0; llbit_clear = clr;
    exp_stall = 1'b0; exp_load = 1'b0;
    step();
    exp_wb_we = 1'b0;
    if (clr) m_llbit = 1'b0;
    llbit_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ex_operation = 4'd0; ex_address = '0; ex_store_data = '0; ex_write_data = '0;
    ex_write_enable = 1'b0; ex_write_address = '0; llbit_clear = 1'b0;
    bif.bus_ack = 1'b0; bif.bus_read_data = '0;
    m_llbit = 1'b0;
    exp_stall = 0; exp_load = 0; exp_req = 0; exp_bw = 0; exp_wb_we = 0;
    exp_mwa = '0; exp_wb_addr = '0; exp_baddr = '0; exp_bwd = '0; exp_wb_data = '0; exp_bsel = '0;
    repeat (2) @(negedge clock);
    check("rst_bus_request", bif.bus_request, 1'b0);
    check("rst_bus_write", bif.bus_write, 1'b0);
    check("rst_bus_address", bif.bus_address, 32'h0);
    check("rst_bus_byte_select", bif.bus_byte_select, 4'h0);
    check("rst_bus_write_data", bif.bus_write_data, 32'h0);
    check("rst_wb_write_enable", wb_write_enable, 1'b0);
    check("rst_wb_write_address", wb_write_address, 5'd0);
    check("rst_wb_write_data", wb_write_data, 32'h0);
    reset = 1'b1;
    step();
    chk_en = 1'b1;

    do_op(4'd0, 32'h0, 32'h0, 5'd1, 1'b1, 32'h00001234, 0, 32'h0);
    check("lit_nop_we", wb_write_enable, 1'b1);
    check("lit_nop_addr", wb_write_address, 5'd1);
    check("lit_nop_data", wb_write_data, 32'h00001234);
    check("lit_nop_stall", stall_cnt, 0);

    do_op(4'd5, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0, 3, 32'h000089AB);
    check("lit_lw_stall_cycles", stall_cnt, 4);
    check("lit_lw_data", wb_write_data, 32'h000089AB);

    do_op(4'd1, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0, 1, 32'h123456F0);
    check("lit_lb_bsel", seen_bsel, 4'b0001);
    check("lit_lb_data", wb_write_data, 32'hFFFFFFF0);
    do_op(4'd2, 32'h103, 32'h0, 5'd5, 1'b1, 32'h0, 0, 32'h123456F0);
    check("lit_lbu_data", wb_write_data, 32'h000000F0);
    do_op(4'd3, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0, 2, 32'h12348001);
    check("lit_lh_bsel", seen_bsel, 4'b0011);
    check("lit_lh_data", wb_write_data, 32'hFFFF8001);
    do_op(4'd4, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0, 0, 32'h80017777);
    check("lit_lhu_data", wb_write_data, 32'h00008001);
    do_op(4'd1, 32'h101, 32'h0, 5'd8, 1'b1, 32'h0, 0, 32'h00800000);

    do_op(4'd6, 32'h101, 32'h000000AB, 5'd9, 1'b0, 32'h0, 1, 32'h0);
    check("lit_sb_write", seen_bw, 1'b1);
    check("lit_sb_bsel", seen_bsel, 4'b0100);
    check("lit_sb_wdata", seen_wdata, 32'hABABABAB);
    check("lit_sb_wb_we", wb_write_enable, 1'b0);
    do_op(4'd7, 32'h102, 32'h1234BEEF, 5'd9, 1'b0, 32'h0, 0, 32'h0);
    do_op(4'd8, 32'h107, 32'hCAFEF00D, 5'd9, 1'b0, 32'h0, 2, 32'h0);
    check("lit_sw_misaligned_addr", seen_addr, 32'h00000104);
    do_op(4'd5, 32'h10E, 32'h0, 5'd10, 1'b1, 32'h0, 0, 32'h55AA55AA);
    do_op(4'd13, 32'h0, 32'h0, 5'd11, 1'b1, 32'h0BADF00D, 0, 32'h0);
    do_op(4'd5, 32'h200, 32'h0, 5'd12, 1'b1, 32'h0, 0, 32'h01020304);
    check("lit_lw_nowait_stall", stall_cnt, 1);
    idle(1'b0);

`ifdef LLSC_EN
    do_op(4'd9, 32'h200, 32'h0, 5'd2, 1'b1, 32'h0, 0, 32'h11111111);
    do_op(4'd10, 32'h200, 32'h77777777, 5'd3, 1'b1, 32'h0, 1, 32'h0);
    check("lit_sc_ok_write", seen_bw, 1'b1);
    check("lit_sc_ok_rt", wb_write_data, 32'd1);
    do_op(4'd9, 32'h200, 32'h0, 5'd2, 1'b1, 32'h0, 0, 32'h22222222);
    idle(1'b1);
    do_op(4'd10, 32'h200, 32'h77777777, 5'd3, 1'b1, 32'h0, 0, 32'h0);
    check("lit_sc_fail_stall", stall_cnt, 0);
    check("lit_sc_fail_rt", wb_write_data, 32'd0);
    idle(1'b0);
`else
    do_op(4'd9, 32'h200, 32'h0, 5'd2, 1'b1, 32'h1, 0, 32'h0);
    check("lit_ll_nop_we", wb_write_enable, 1'b0);
    do_op(4'd10, 32'h200, 32'h0, 5'd3, 1'b1, 32'h1, 0, 32'h0);
    check("lit_sc_nop_stall", stall_cnt, 0);
    idle(1'b0);
`endif

    chk_en = 1'b0;
    ex_operation = 4'd5; ex_address = 32'h300; ex_write_address = 5'd7; ex_write_enable = 1'b1;
    step();
    step();
    check("pre_rst_bus_request", bif.bus_request, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_bus_request", bif.bus_request, 1'b0);
    check("async_rst_wb_we", wb_write_enable, 1'b0);
    ex_operation = 4'd0; ex_write_enable = 1'b0;
    bif.bus_ack = 1'b1; bif.bus_read_data = 32'hFFFFFFFF;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_rst_bus_request", bif.bus_request, 1'b0);
      check("post_rst_wb_we", wb_write_enable, 1'b0);
      check("post_rst_stall", stall_request, 1'b0);
    end
    bif.bus_ack = 1'b0;
    m_llbit = 1'b0;
    exp_stall = 0; exp_load = 0; exp_req = 0; exp_wb_we = 0;
    chk_en = 1'b1;
    do_op(4'd2, 32'h302, 32'h0, 5'd13, 1'b1, 32'h0, 1, 32'hA1B2C3D4);
    check("lit_post_rst_lbu", wb_write_data, 32'h000000C3);
    idle(1'b0);
    @(negedge clock);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
